// File: rtl/fp_to_pcm_if.sv
// ---------------------------------------------------------------------------
// fp_to_pcm_if
// Request/result bundle between the FP divider wrapper (master side) and the
// float-to-PCM converter (slave side).
//   start   : one-cycle request, fp_in valid in the same cycle
//   fp_in   : IEEE-754 single-precision operand, full scale [-1.0, 1.0)
//   busy    : converter is not idle
//   done    : one-cycle pulse, pcm_out/sat/nan valid from this cycle on
//   pcm_out : signed two's-complement sample, held until the next done
//   sat     : last result was saturated
//   nan     : last operand was NaN
// ---------------------------------------------------------------------------
interface fp_to_pcm_if #(
    parameter int OUT_WIDTH = 24
);
    logic                 start;
    logic [31:0]          fp_in;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] pcm_out;
    logic                 sat;
    logic                 nan;

    modport master (
        output start, fp_in,
        input  busy, done, pcm_out, sat, nan
    );

    modport slave (
        input  start, fp_in,
        output busy, done, pcm_out, sat, nan
    );
endinterface

// File: rtl/fp_to_pcm.sv
// ---------------------------------------------------------------------------
// fp_to_pcm
// Converts an IEEE-754 single-precision value into a signed OUT_WIDTH-bit PCM
// sample: pcm = trunc_toward_zero(value * 2^(OUT_WIDTH-1)), saturated to
// [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The mantissa is right-shifted one bit
// per cycle, so normal operands take sh+3 cycles and special/zero operands 2.
// Ports:
//   clock  : system clock, all state on the rising edge
//   resetn : asynchronous active-low reset, aborts any conversion in flight
//   conv   : slave side of fp_to_pcm_if (start/fp_in in, busy/done/pcm_out/
//            sat/nan out)
// ---------------------------------------------------------------------------
module fp_to_pcm #(
    parameter int OUT_WIDTH = 24
) (
    input  logic        clock,
    input  logic        resetn,
    fp_to_pcm_if.slave  conv
);
    localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SHIFT,
        S_NEGATE,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_sign;
    logic [7:0]           r_exp;
    logic [23:0]          r_mag;
    logic [4:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [OUT_WIDTH-1:0] r_pcm;
    logic                 r_sat;
    logic                 r_nan;

    logic [8:0]           w_sh;
    logic                 w_frac_nz;
    logic [OUT_WIDTH-1:0] w_mag;

    // Right-shift distance that aligns the 24-bit mantissa to the PCM LSB.
    // Only meaningful once |v| < 1.0 is known, where it is always >= 1.
    assign w_sh      = 9'd151 - 9'(OUT_WIDTH) - {1'b0, r_exp};
    assign w_frac_nz = |r_mag[22:0];
    // After the shift the magnitude is below 2^(OUT_WIDTH-1), so the upper
    // mantissa bits are zero and the low OUT_WIDTH bits hold it exactly.
    assign w_mag     = r_mag[OUT_WIDTH-1:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= 8'd0;
            r_mag   <= 24'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pcm   <= '0;
            r_sat   <= 1'b0;
            r_nan   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (conv.start) begin
                        r_sign  <= conv.fp_in[31];
                        r_exp   <= conv.fp_in[30:23];
                        r_mag   <= {1'b1, conv.fp_in[22:0]};
                        r_busy  <= 1'b1;
                        r_state <= S_CLASSIFY;
                    end
                end

                S_CLASSIFY: begin
                    if (r_exp == 8'hFF && w_frac_nz) begin
                        // NaN
                        r_pcm   <= '0;
                        r_sat   <= 1'b0;
                        r_nan   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_exp == 8'hFF || r_exp >= 8'd127) begin
                        // Infinity or |v| >= 1.0 (exactly -1.0 lands here too)
                        r_pcm   <= r_sign ? SAT_NEG : SAT_POS;
                        r_sat   <= 1'b1;
                        r_nan   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_exp == 8'd0 || w_sh >= 9'd24) begin
                        // Zero, denormal, or too small to reach the PCM LSB;
                        // -0.0 also lands here and yields 0.
                        r_pcm   <= '0;
                        r_sat   <= 1'b0;
                        r_nan   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= w_sh[4:0];
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_mag <= r_mag >> 1;
                    r_cnt <= r_cnt - 5'd1;
                    // Leaving on count 1 makes this state last exactly sh cycles.
                    if (r_cnt == 5'd1) begin
                        r_state <= S_NEGATE;
                    end
                end

                S_NEGATE: begin
                    r_pcm   <= r_sign ? ({OUT_WIDTH{1'b0}} - w_mag) : w_mag;
                    r_sat   <= 1'b0;
                    r_nan   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    // A start seen here is dropped, not queued.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign conv.busy    = r_busy;
    assign conv.done    = r_done;
    assign conv.pcm_out = r_pcm;
    assign conv.sat     = r_sat;
    assign conv.nan     = r_nan;

endmodule

// File: tb/tb_fp_to_pcm.sv
module tb_fp_to_pcm;
    localparam int W = 24;

    typedef struct {
        logic [31:0]  fp;
        logic [W-1:0] pcm;
        logic         sat;
        logic         nan;
        int           lat;
    } vec_t;

    typedef struct {
        logic [31:0]  fp;
        logic [W-1:0] pcm;
        logic         sat;
        logic         nan;
        int           lat;
        int           s_cyc;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    fp_to_pcm_if #(.OUT_WIDTH(W)) conv_if ();

    fp_to_pcm #(.OUT_WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .conv   (conv_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: counts cycles and scores every done pulse against the queue.
    always @(negedge clock) begin
        ncyc = ncyc + 1;
        if (conv_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 pcm=0x%0h, expected no done", conv_if.pcm_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("pcm_out", 32'(conv_if.pcm_out), 32'(mon_e.pcm));
                check("sat", 32'(conv_if.sat), 32'(mon_e.sat));
                check("nan", 32'(conv_if.nan), 32'(mon_e.nan));
                check("latency", 32'(ncyc - mon_e.s_cyc), 32'(mon_e.lat));
                check("busy_at_done", 32'(conv_if.busy), 32'd1);
                $display("txn fp=0x%08h pcm=0x%06h sat=%0b nan=%0b lat=%0d (exp pcm=0x%06h sat=%0b nan=%0b lat=%0d)",
                         mon_e.fp, conv_if.pcm_out, conv_if.sat, conv_if.nan, ncyc - mon_e.s_cyc,
                         mon_e.pcm, mon_e.sat, mon_e.nan, mon_e.lat);
            end
        end
    end

    // Drive one start pulse; optionally push the expected result.
    task automatic issue(input logic [31:0] fp, input bit push, input vec_t v);
        exp_t e;
        @(negedge clock);
        #1;
        conv_if.start = 1'b1;
        conv_if.fp_in = fp;
        if (push) begin
            e.fp    = fp;
            e.pcm   = v.pcm;
            e.sat   = v.sat;
            e.nan   = v.nan;
            e.lat   = v.lat;
            e.s_cyc = ncyc;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        conv_if.start = 1'b0;
    endtask

    // Wait (bounded) for done, checking busy every cycle, then check return
    // to idle and that sat/nan are held.
    task automatic wait_done(input int budget, input logic exp_sat, input logic exp_nan);
        int n    = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            @(negedge clock);
            #1;
            n++;
            check("busy_while_active", 32'(conv_if.busy), 32'd1);
            if (conv_if.done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
            sb_q.delete();
        end
        @(negedge clock);
        #1;
        check("busy_after_done", 32'(conv_if.busy), 32'd0);
        check("done_one_cycle", 32'(conv_if.done), 32'd0);
        check("sat_held", 32'(conv_if.sat), 32'(exp_sat));
        check("nan_held", 32'(conv_if.nan), 32'(exp_nan));
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.fp, 1'b1, v);
        wait_done(40, v.sat, v.nan);
    endtask

    initial begin
        vec_t v;
        vec_t dummy;
        dummy = '{32'h0, 24'h0, 1'b0, 1'b0, 0};

        // {fp_in, pcm_out, sat, nan, latency}
        vecs.push_back('{32'h3F000000, 24'h400000, 1'b0, 1'b0, 4});   // 0.5
        vecs.push_back('{32'hBE800000, 24'hE00000, 1'b0, 1'b0, 5});   // -0.25
        vecs.push_back('{32'h3F7FFFFF, 24'h7FFFFF, 1'b0, 1'b0, 4});   // just below 1.0
        vecs.push_back('{32'h3F800000, 24'h7FFFFF, 1'b1, 1'b0, 2});   // 1.0
        vecs.push_back('{32'hC0000000, 24'h800000, 1'b1, 1'b0, 2});   // -2.0
        vecs.push_back('{32'hFF800000, 24'h800000, 1'b1, 1'b0, 2});   // -Inf
        vecs.push_back('{32'h7FC00000, 24'h000000, 1'b0, 1'b1, 2});   // NaN
        vecs.push_back('{32'h33800000, 24'h000000, 1'b0, 1'b0, 2});   // 2^-24
        vecs.push_back('{32'h80000000, 24'h000000, 1'b0, 1'b0, 2});   // -0.0
        vecs.push_back('{32'hBF800000, 24'h800000, 1'b1, 1'b0, 2});   // -1.0 exactly
        vecs.push_back('{32'h7F800000, 24'h7FFFFF, 1'b1, 1'b0, 2});   // +Inf
        vecs.push_back('{32'h34000000, 24'h000001, 1'b0, 1'b0, 26});  // 2^-23, sh=23
        vecs.push_back('{32'hB4000000, 24'hFFFFFF, 1'b0, 1'b0, 26});  // -2^-23
        vecs.push_back('{32'h3F400000, 24'h600000, 1'b0, 1'b0, 4});   // 0.75
        vecs.push_back('{32'hBF7FFFFF, 24'h800001, 1'b0, 1'b0, 4});   // just above -1.0
        vecs.push_back('{32'h3EAAAAAB, 24'h2AAAAA, 1'b0, 1'b0, 5});   // ~1/3, truncated
        vecs.push_back('{32'hFFC00001, 24'h000000, 1'b0, 1'b1, 2});   // negative NaN
        vecs.push_back('{32'h00400000, 24'h000000, 1'b0, 1'b0, 2});   // denormal

        conv_if.start = 1'b0;
        conv_if.fp_in = 32'h0;
        resetn        = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_busy", 32'(conv_if.busy), 32'd0);
        check("reset_done", 32'(conv_if.done), 32'd0);
        check("reset_pcm", 32'(conv_if.pcm_out), 32'd0);
        check("reset_sat", 32'(conv_if.sat), 32'd0);
        check("reset_nan", 32'(conv_if.nan), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Start during SHIFT is ignored: 2^-14 (sh=14) -> 0x000200 after 17.
        v = '{32'h38800000, 24'h000200, 1'b0, 1'b0, 17};
        issue(v.fp, 1'b1, v);
        @(negedge clock);
        @(negedge clock);
        #1;
        conv_if.start = 1'b1;
        conv_if.fp_in = 32'h3F000000;
        @(posedge clock);
        #1;
        conv_if.start = 1'b0;
        wait_done(40, 1'b0, 1'b0);
        repeat (8) @(negedge clock);

        // Start during the DONE cycle is ignored.
        v = '{32'h3F800000, 24'h7FFFFF, 1'b1, 1'b0, 2};
        issue(v.fp, 1'b1, v);
        @(negedge clock);
        @(negedge clock);
        #1;
        check("in_done_cycle", 32'(conv_if.done), 32'd1);
        conv_if.start = 1'b1;
        conv_if.fp_in = 32'h3F000000;
        @(posedge clock);
        #1;
        conv_if.start = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        check("start_in_done_ignored_busy", 32'(conv_if.busy), 32'd0);
        check("start_in_done_pcm_held", 32'(conv_if.pcm_out), 32'h7FFFFF);

        // Reset during SHIFT aborts with no done.
        issue(32'h3A800000, 1'b0, dummy);
        repeat (4) @(negedge clock);
        #1;
        check("shift_busy_before_reset", 32'(conv_if.busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_busy", 32'(conv_if.busy), 32'd0);
        check("abort_done", 32'(conv_if.done), 32'd0);
        check("abort_pcm", 32'(conv_if.pcm_out), 32'd0);
        check("abort_sat", 32'(conv_if.sat), 32'd0);
        check("abort_nan", 32'(conv_if.nan), 32'd0);
        @(negedge clock);
        #1;
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        run_vec('{32'h3F000000, 24'h400000, 1'b0, 1'b0, 4});

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
